// File: rtl/jesd_tx_framer.sv
// jesd_tx_framer: single-lane JESD204B TX framer (CGS -> ILAS -> DATA) with a free-running LMFC.
// Build option JESD_TX_SCRAMBLE_EN: scramble DATA octets instead of /A/ /F/ character replacement.
module jesd_tx_framer #(
  parameter int unsigned FRAMES_PER_MF = 16,
  parameter int unsigned ILAS_MF       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync_n,
  input  logic [15:0] tx_data_in,
  output logic        tx_ready,
  output logic [15:0] txd,
  output logic [1:0]  tx_k,
  output logic        link_up
);

  localparam int unsigned   LW        = $clog2(FRAMES_PER_MF);
  localparam int unsigned   MW        = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam logic [LW-1:0] LMFC_LAST = LW'(FRAMES_PER_MF - 1);
  localparam logic [MW-1:0] MF_LAST   = MW'(ILAS_MF - 1);

  typedef enum logic [1:0] {ST_CGS, ST_ILAS, ST_DATA} state_t;

  state_t      state, state_nxt;
  logic        sync_m, sync_s;
  logic [LW-1:0] lmfc;
  logic [MW-1:0] mf_cnt;
  logic [1:0]  low_cnt;
  logic        lmfc_last;
  logic [7:0]  ilas_even;
  logic [15:0] txd_nxt;
  logic [1:0]  k_nxt;

  assign lmfc_last = (lmfc == LMFC_LAST);
  assign ilas_even = 8'(lmfc) << 1;
  assign tx_ready  = (state == ST_DATA);
  assign link_up   = (state == ST_DATA);

`ifdef JESD_TX_SCRAMBLE_EN
  logic [14:0] scr, scr_nxt;
  logic [15:0] ser_out;

  // Serial order is octet 0 bit 7 first; ser_out[15] is the first bit on the wire.
  always_comb begin
    scr_nxt = scr;
    ser_out = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      ser_out[15-i] = (i < 8 ? tx_data_in[7-i] : tx_data_in[23-i]) ^ scr_nxt[13] ^ scr_nxt[14];
      scr_nxt       = {scr_nxt[13:0], ser_out[15-i]};
    end
  end
`else
  logic [7:0] prev_oct1;
  logic       prev_vld;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CGS:  if (sync_s && lmfc_last) state_nxt = ST_ILAS;
      ST_ILAS: begin
        if (!sync_s)                          state_nxt = ST_CGS;
        else if (lmfc_last && mf_cnt == MF_LAST) state_nxt = ST_DATA;
      end
      ST_DATA: if (!sync_s && low_cnt == 2'd3) state_nxt = ST_CGS;
      default: state_nxt = ST_CGS;
    endcase
  end

  always_comb begin
    txd_nxt = 16'hBCBC;
    k_nxt   = 2'b11;
    unique case (state)
      ST_ILAS: begin
        txd_nxt = {ilas_even | 8'h01, ilas_even};
        k_nxt   = 2'b00;
        if (lmfc == '0) begin
          txd_nxt[7:0] = 8'h1C;
          k_nxt[0]     = 1'b1;
        end
        if (lmfc == '0 && mf_cnt == MW'(1)) begin
          txd_nxt[15:8] = 8'h9C;
          k_nxt[1]      = 1'b1;
        end else if (lmfc_last) begin
          txd_nxt[15:8] = 8'h7C;
          k_nxt[1]      = 1'b1;
        end
      end
      ST_DATA: begin
`ifdef JESD_TX_SCRAMBLE_EN
        txd_nxt = {ser_out[7:0], ser_out[15:8]};
        k_nxt   = 2'b00;
`else
        txd_nxt = tx_data_in;
        k_nxt   = 2'b00;
        // Repeat detection uses the raw previous input, never the replaced octet.
        if (prev_vld && tx_data_in[15:8] == prev_oct1) begin
          txd_nxt[15:8] = lmfc_last ? 8'h7C : 8'hFC;
          k_nxt[1]      = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_m  <= 1'b0;
      sync_s  <= 1'b0;
      state   <= ST_CGS;
      lmfc    <= '0;
      mf_cnt  <= '0;
      low_cnt <= '0;
      txd     <= 16'hBCBC;
      tx_k    <= 2'b11;
`ifdef JESD_TX_SCRAMBLE_EN
      scr     <= '1;
`else
      prev_oct1 <= '0;
      prev_vld  <= 1'b0;
`endif
    end else begin
      sync_m  <= sync_n;
      sync_s  <= sync_m;
      state   <= state_nxt;
      lmfc    <= lmfc_last ? '0 : lmfc + 1'b1;
      mf_cnt  <= (state == ST_ILAS) ? (lmfc_last ? mf_cnt + 1'b1 : mf_cnt) : '0;
      low_cnt <= (state == ST_DATA && !sync_s) ? low_cnt + 2'd1 : '0;
      txd     <= txd_nxt;
      tx_k    <= k_nxt;
`ifdef JESD_TX_SCRAMBLE_EN
      scr     <= (state == ST_DATA) ? scr_nxt : '1;
`else
      prev_oct1 <= tx_data_in[15:8];
      prev_vld  <= (state == ST_DATA);
`endif
    end
  end

endmodule

// File: tb/tb_jesd_tx_framer.sv
// Bench for jesd_tx_framer: random sync/data stimulus, a frame-level reference model
// pushes expected words into a scoreboard that a monitor drains every cycle.
module tb_jesd_tx_framer;

  localparam int K   = 16;
  localparam int NMF = 4;
  localparam int PH_CGS  = 0;
  localparam int PH_ILAS = 1;
  localparam int PH_DATA = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync_n = 1'b0;
  logic [15:0] tx_data_in = '0;
  logic        tx_ready, link_up;
  logic [15:0] txd;
  logic [1:0]  tx_k;

  jesd_tx_framer #(.FRAMES_PER_MF(K), .ILAS_MF(NMF)) dut (
    .clk(clk), .rst(rst), .sync_n(sync_n), .tx_data_in(tx_data_in),
    .tx_ready(tx_ready), .txd(txd), .tx_k(tx_k), .link_up(link_up)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        up;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  int         phase = PH_CGS;
  int         lmfc_m = 0;
  int         ilas_pos = 0;
  int         data_cnt = 0;
  int         low_run = 0;
  logic       sync_hist[$] = '{1'b0, 1'b0};
  logic [7:0] last_oct1 = '0;
  logic       sq[$];
  logic [7:0] last_drv1 = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    logic ss, b;
    logic [15:0] d;
    int c, mf, pos;
    e = '0;
    if (rst) begin
      phase = PH_CGS; lmfc_m = 0; ilas_pos = 0; data_cnt = 0; low_run = 0;
      sync_hist = '{1'b0, 1'b0};
      e.d = 16'hBCBC; e.k = 2'b11; e.up = 1'b0;
    end else begin
      ss = sync_hist.pop_front();
      sync_hist.push_back(sync_n);
      d = tx_data_in;
      case (phase)
        PH_ILAS: begin
          c  = ilas_pos % K;
          mf = ilas_pos / K;
          e.d = {8'(2*c+1), 8'(2*c)};
          e.k = 2'b00;
          if (c == 0) begin e.d[7:0] = 8'h1C; e.k[0] = 1'b1; end
          if (c == 0 && mf == 1) begin e.d[15:8] = 8'h9C; e.k[1] = 1'b1; end
          else if (c == K-1) begin e.d[15:8] = 8'h7C; e.k[1] = 1'b1; end
        end
        PH_DATA: begin
          e.k = 2'b00;
`ifdef JESD_TX_SCRAMBLE_EN
          for (int i = 0; i < 16; i++) begin
            pos = (i < 8) ? 7 - i : 23 - i;
            b = d[pos] ^ sq[sq.size()-14] ^ sq[sq.size()-15];
            sq.push_back(b);
            e.d[pos] = b;
          end
          while (sq.size() > 15) void'(sq.pop_front());
`else
          e.d = d;
          if (data_cnt > 0 && d[15:8] == last_oct1) begin
            e.d[15:8] = (lmfc_m == K-1) ? 8'h7C : 8'hFC;
            e.k[1] = 1'b1;
          end
`endif
        end
        default: begin e.d = 16'hBCBC; e.k = 2'b11; end
      endcase
      case (phase)
        PH_CGS: if (ss && lmfc_m == K-1) begin phase = PH_ILAS; ilas_pos = 0; end
        PH_ILAS: begin
          if (!ss) phase = PH_CGS;
          else begin
            ilas_pos++;
            if (ilas_pos == K*NMF) begin
              phase = PH_DATA; data_cnt = 0; low_run = 0;
              sq.delete();
              for (int i = 0; i < 15; i++) sq.push_back(1'b1);
            end
          end
        end
        default: begin
          last_oct1 = d[15:8];
          data_cnt++;
          low_run = ss ? 0 : low_run + 1;
          if (low_run == 4) phase = PH_CGS;
        end
      endcase
      lmfc_m = (lmfc_m + 1) % K;
      e.up = (phase == PH_DATA);
    end
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty actual=0 required=1 t=%0t", $time);
    end else begin
      e = sb.pop_front();
      chk("txd", txd, e.d);
      chk("tx_k", {14'b0, tx_k}, {14'b0, e.k});
      chk("link_up", {15'b0, link_up}, {15'b0, e.up});
      chk("tx_ready", {15'b0, tx_ready}, {15'b0, e.up});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  function automatic logic [15:0] rnd_data();
    logic [15:0] d;
    d = 16'($urandom);
    if ($urandom_range(0, 2) == 0) d[15:8] = last_drv1;
`ifdef JESD_TX_SCRAMBLE_EN
    if (phase == PH_DATA && data_cnt == 0) d = 16'h0000;
`endif
    last_drv1 = d[15:8];
    return d;
  endfunction

  // Inputs change 2 time units after a rising edge and are sampled at the next one.
  task automatic step(input logic sn, input logic [15:0] d);
    sync_n = sn;
    tx_data_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_link(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (phase != PH_DATA && n < max_cyc) begin
      step(1'b1, rnd_data());
      n++;
    end
    chk(tag, {15'b0, link_up}, 16'h0001);
  endtask

  task automatic wait_ilas(input int max_cyc);
    int n;
    n = 0;
    while (phase != PH_ILAS && n < max_cyc) begin
      step(1'b1, rnd_data());
      n++;
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_txd"}, txd, 16'hBCBC);
    chk({tag, "_k"}, {14'b0, tx_k}, 16'h0003);
    chk({tag, "_up"}, {15'b0, link_up}, 16'h0000);
    chk({tag, "_ready"}, {15'b0, tx_ready}, 16'h0000);
    @(posedge clk);
    #2;
    repeat (2) step(1'b1, rnd_data());
    rst = 1'b0;
  endtask

  task automatic drop_link();
    repeat (6) step(1'b0, rnd_data());
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (40) step(1'b0, rnd_data());

    wait_link(200, "link_first");
    repeat (60) step(1'b1, rnd_data());

`ifndef JESD_TX_SCRAMBLE_EN
    while (lmfc_m != 3) step(1'b1, rnd_data());
    step(1'b1, 16'h0000);
    step(1'b1, 16'h3412);
    step(1'b1, 16'h3456);
    while (lmfc_m != 13) step(1'b1, rnd_data());
    step(1'b1, 16'h0000);
    step(1'b1, 16'h3412);
    step(1'b1, 16'h3456);
`endif

    repeat (3) step(1'b0, rnd_data());
    repeat (12) step(1'b1, rnd_data());
    chk("glitch3_up", {15'b0, link_up}, 16'h0001);
    repeat (4) step(1'b0, rnd_data());
    repeat (3) step(1'b1, rnd_data());
    chk("glitch4_up", {15'b0, link_up}, 16'h0000);
    wait_link(200, "relink_glitch4");

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 5)) step(1'b0, rnd_data());
      repeat ($urandom_range(5, 30)) step(1'b1, rnd_data());
      if (phase != PH_DATA) wait_link(200, "relink_rand");
    end

    drop_link();
    wait_ilas(100);
    repeat ($urandom_range(2, 50)) step(1'b1, rnd_data());
    step(1'b0, rnd_data());
    repeat (4) step(1'b1, rnd_data());
    wait_link(300, "relink_ilas_abort");

    drop_link();
    wait_ilas(100);
    repeat ($urandom_range(3, 40)) step(1'b1, rnd_data());
    reset_pulse("rst_ilas");
    wait_link(300, "relink_rst_ilas");

    repeat ($urandom_range(5, 30)) step(1'b1, rnd_data());
    reset_pulse("rst_data");
    wait_link(300, "relink_rst_data");
    repeat (50) step(1'b1, rnd_data());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jesd_tx_framer.md
JESD_TX_FRAMER -- requirements
Module: jesd_tx_framer

Interface
REQ-001 Parameter FRAMES_PER_MF, default 16, meaning frames (= clock cycles) per multiframe (K); legal range 4..32.
REQ-002 Parameter ILAS_MF, default 4, meaning number of multiframes in the initial lane alignment sequence (ILAS); legal range 1..8.
REQ-003 Port clk  input  1  single clock; the SERDES TX reference clock; all logic on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port sync_n  input  1  converter SYNC~ request, asynchronous, active-low.
REQ-006 Port tx_data_in  input  16  user frame; [7:0] = octet 0 (sent first), [15:8] = octet 1.
REQ-007 Port tx_ready  output  1  high while in DATA; tx_data_in is consumed on every cycle tx_ready is high.
REQ-008 Port txd  output  16  octets to the DCU TX lane; same octet order as tx_data_in.
REQ-009 Port tx_k  output  2  K-character flag per octet; bit 0 = octet 0.
REQ-010 Port link_up  output  1  high while in DATA.

Function
REQ-011 sync_n SHALL pass through a 2-flop synchronizer (sync_s) before any use.
REQ-012 A free-running LMFC counter SHALL count 0..FRAMES_PER_MF-1 and wrap; one frame (2 octets) per cycle.
REQ-013 States SHALL be CGS, ILAS, DATA; txd/tx_k SHALL be registered, reflecting the state and LMFC value of the previous cycle.
REQ-014 CGS: txd = 16'hBCBC (K28.5 both octets), tx_k = 2'b11.
REQ-015 CGS->ILAS SHALL occur when sync_s = 1 and LMFC = K-1, so that ILAS starts at LMFC 0; otherwise the block stays in CGS.
REQ-016 ILAS octet j (0/1) at LMFC c: data = 2c+j (8-bit), tx_k = 0, with these overrides in priority order: octet 0 at c=0 -> 8'h1C K28.0 /R/, k=1; octet 1 at c=0 in multiframe 1 -> 8'h9C K28.4 /Q/, k=1; octet 1 at c=K-1 -> 8'h7C K28.3 /A/, k=1.
REQ-017 After ILAS_MF complete multiframes, the block SHALL enter DATA at LMFC 0.
REQ-018 DATA: txd SHALL carry tx_data_in of the previous cycle, processed per REQ-025/026, with 1 cycle latency.
REQ-019 In DATA, sync_s low for 4 or more consecutive cycles SHALL force CGS on the 4th cycle; shorter low pulses SHALL be ignored.
REQ-020 In ILAS, sync_s low on any cycle SHALL return the block to CGS the next cycle.
REQ-021 tx_ready and link_up SHALL be combinational decodes of state == DATA.

Reset
REQ-022 Asserting rst SHALL asynchronously force: state CGS, LMFC 0, synchronizer flops 0, txd 16'hBCBC, tx_k 2'b11, tx_ready 0, link_up 0, and scrambler state 15'h7FFF.
REQ-023 Reset mid-ILAS or mid-DATA SHALL abort immediately with no partial frame.

Configuration
REQ-024 Macro JESD_TX_SCRAMBLE_EN SHALL select DATA-state processing.
REQ-025 With JESD_TX_SCRAMBLE_EN defined, DATA octets SHALL be scrambled with 1+x^14+x^15: s[n] = d[n]^s[n-14]^s[n-15]; bit order octet 0 bit 7..0, then octet 1 bit 7..0; 15-bit state reloaded to all ones on DATA entry; tx_k = 0; no character replacement.
REQ-026 With JESD_TX_SCRAMBLE_EN undefined, there SHALL be no scrambling. If input octet 1 equals the previous cycle's input octet 1, octet 1 SHALL be replaced with 8'h7C /A/ (k=1) when LMFC = K-1, and with 8'hFC K28.7 /F/ (k=1) otherwise. The comparison SHALL use unreplaced input values, and the first DATA cycle SHALL never be replaced.

Verification
REQ-027 rst pulse, sync_n held 0 -> txd=16'hBCBC, tx_k=2'b11, tx_ready=0 indefinitely.
REQ-028 Defaults, sync_n raised -> CGS until LMFC 15; first ILAS word 16'h011C/k=01; multiframe 1 first word 16'h9C1C/k=11; each multiframe last word 16'h7C1E/k=10; DATA after exactly 64 ILAS cycles.
REQ-029 Scramble off, DATA inputs 16'h3412 then 16'h3456 -> txd 16'h3412/k=00 then 16'hFC56/k=10; same pair with the second at LMFC 15 -> 16'h7C56/k=10.
REQ-030 In DATA, sync_n low 3 cycles -> link_up stays 1; low 4 cycles -> link_up 0, txd returns to 16'hBCBC.
REQ-031 Scramble on, first DATA input 16'h0000 -> txd 16'h0200, tx_k 2'b00.
REQ-032 rst asserted mid-ILAS -> outputs immediately at reset values; with sync_n high, ILAS restarts only at the next LMFC 0.
